// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (LSB first, NB_DATA data bits,
// NB_STOP stop bits). Reassembles each serial frame into a parallel byte.
//
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit
// between data and stop bits, plus the o_parity_error port).
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous, active-high reset
//   i_rx           serial line, idle high, asynchronous to i_clock
//   o_data         last good byte, holds between frames
//   o_rx_done      one-cycle pulse, o_data newly updated
//   o_frame_error  one-cycle pulse, a stop bit was sampled low
//   o_busy         high whenever the receiver is not idle
//   o_parity_error one-cycle pulse with o_rx_done on parity mismatch
//                  (only with UART_RX_PARITY_EN)
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | validating the start bit at its midpoint
// DATA   | sampling NB_DATA data bits, one per 16 ticks
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling NB_STOP stop bits
// BREAK  | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int BAUD_RATE       = 9600,
  parameter int SYS_CLOCK       = 100000000,
  parameter int TICK_RATE       = SYS_CLOCK / (BAUD_RATE * 16),
  parameter int NB_TICK_COUNTER = $clog2(TICK_RATE),
  parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_error,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_error,
`endif
  output logic               o_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic                       rx_meta_q, rx_s_q;
  logic [NB_TICK_COUNTER-1:0] tick_cnt_q;
  logic                       tick;
  logic [3:0]                 s_cnt_q, s_cnt_d;
  logic [NB_DATA_COUNTER-1:0] n_cnt_q, n_cnt_d;
  logic [NB_DATA-1:0]         shift_q, shift_d;
  logic [NB_DATA-1:0]         data_q, data_d;
  logic                       stop_err_q, stop_err_d;
  logic                       done_q, done_d;
  logic                       ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                       par_bit_q, par_bit_d;
  logic                       perr_q, perr_d;
`endif

  // Synchroniser resets to the idle line level so reset release cannot
  // look like a start bit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running prescaler; never realigned to the frame.
  assign tick = (tick_cnt_q == NB_TICK_COUNTER'(TICK_RATE - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)   tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      stop_err_q <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      n_cnt_q    <= n_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      stop_err_q <= stop_err_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    n_cnt_d    = n_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    stop_err_d = stop_err_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              s_cnt_d = '0;
              n_cnt_d = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = '0;
            shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
            if (n_cnt_q == NB_DATA_COUNTER'(NB_DATA - 1)) begin
              // n_cnt is reused to count stop bits.
              n_cnt_d    = '0;
              stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
              state_d    = PARITY;
`else
              state_d    = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d   = '0;
            par_bit_d = rx_s_q;
            state_d   = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = '0;
            if (n_cnt_q == NB_DATA_COUNTER'(NB_STOP - 1)) begin
              if (stop_err_q || !rx_s_q) begin
                ferr_d  = 1'b1;
                state_d = BREAK;
              end else begin
                done_d  = 1'b1;
                data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                perr_d  = (^shift_q) ^ par_bit_q;
`endif
                state_d = IDLE;
              end
            end else begin
              n_cnt_d    = n_cnt_q + 1'b1;
              stop_err_d = stop_err_q | ~rx_s_q;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int TICK = 4;
  localparam int BIT  = TICK * 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       done, ferr, busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         n_done = 0;
  int         n_ferr = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .NB_DATA(8), .NB_STOP(1), .BAUD_RATE(9600), .SYS_CLOCK(614400), .TICK_RATE(TICK)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_rx(rx),
    .o_data(data),
    .o_rx_done(done),
    .o_frame_error(ferr),
`ifdef UART_RX_PARITY_EN
    .o_parity_error(perr),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done || ferr)) begin
      if (done) n_done++;
      if (ferr) n_ferr++;
      check("pulse_exclusive", {31'd0, done & ferr}, 32'd0);
      check("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind_done", {31'd0, done}, {31'd0, ~e.ferr});
        check("kind_ferr", {31'd0, ferr}, {31'd0, e.ferr});
        check("data", {24'd0, data}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
        check("parity_err", {31'd0, perr}, {31'd0, e.perr});
`endif
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk) rx = b;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    if (stop) begin
      e.ferr = 1'b0; e.perr = par_flip; e.data = b;
      last_good = b;
    end else begin
      e.ferr = 1'b1; e.perr = 1'b0; e.data = last_good;
    end
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4 * BIT) begin
      @(negedge clk);
      k++;
    end
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    logic       busy_seen;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Single good frame
    send(8'hA5, 1'b1, 1'b0);
    drain("drain_a5");
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_busy", {31'd0, busy}, 32'd0);
    check("a5_count", n_done, 32'd1);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    drain("drain_b2b");
    check("b2b_count", n_done, 32'd3);
    check("b2b_data", {24'd0, data}, 32'hFF);

    // Start-bit glitch: 3 ticks low
    held = data;
    busy_seen = 1'b0;
    @(negedge clk) rx = 1'b0;
    repeat (12) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    rx = 1'b1;
    repeat (2 * BIT) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_no_done", n_done, 32'd3);
    check("glitch_no_ferr", n_ferr, 32'd0);
    check("glitch_data", {24'd0, data}, {24'd0, held});

    // Framing error with line held low afterwards
    send(8'h3C, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_no_done", n_done, 32'd3);
    check("ferr_count", n_ferr, 32'd1);
    check("ferr_data", {24'd0, data}, 32'hFF);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check("break_released", {31'd0, busy}, 32'd0);
    send(8'h81, 1'b1, 1'b0);
    drain("drain_81");
    check("after_ferr_data", {24'd0, data}, 32'h81);

    // Reset in mid-frame
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(held[i] ^ 1'b1 ^ (8'h5A >> i & 8'h01) ^ held[i] ^ 1'b1);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_data", {24'd0, data}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_ferr", {31'd0, ferr}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * BIT) @(negedge clk);
    check("abort_no_done", n_done, 32'd4);
    send(8'hC3, 1'b1, 1'b0);
    drain("drain_c3");
    check("c3_data", {24'd0, data}, 32'hC3);
    check("c3_count", n_done, 32'd5);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b1);
    drain("drain_parity");
    check("parity_count", n_done, 32'd7);
`endif

    repeat (BIT) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("ferr_total", n_ferr, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
